// File: rtl/audio_record_playback.sv
// Voice recorder: captures 7-bit decimated mic samples into block RAM and replays them as PWM.
// Define PLAYBACK_LOOP_EN to loop playback at end of data instead of returning to IDLE.
module audio_record_playback #(
  parameter int unsigned DEPTH         = 65536,
  parameter int unsigned SAMPLE_PERIOD = 4000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [6:0]               amplitude,
  input  logic                     amplitude_valid,
  input  logic                     start_record,
  input  logic                     start_play,
  input  logic                     stop,
  output logic                     aud_pwm,
  output logic                     aud_sd,
  output logic                     recording,
  output logic                     playing,
  output logic [$clog2(DEPTH):0]   sample_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned DW = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   period_q, period_d;
  logic [DW-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [DW-1:0]   pwm_level_q, pwm_level_d;
  logic            load_q, load_d;
  logic            aud_pwm_q, aud_pwm_d;
  logic            aud_sd_q, aud_sd_d;
  logic            recording_q, recording_d;
  logic            playing_q, playing_d;

  logic            mem_we_c;
  logic            strobe_c;
  logic [AW-1:0]   rd_addr_c;
  logic [DW-1:0]   rd_data_q;

  // Sample buffer: contents are never reset; sample_count gates what is valid.
  logic [DW-1:0]   mem [DEPTH];

  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[wr_ptr_q] <= amplitude;
    end
    if (strobe_c) begin
      rd_data_q <= mem[rd_addr_c];
    end
  end

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      period_q    <= '0;
      pwm_cnt_q   <= '0;
      pwm_level_q <= '0;
      load_q      <= 1'b0;
      aud_pwm_q   <= 1'b0;
      aud_sd_q    <= 1'b0;
      recording_q <= 1'b0;
      playing_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      period_q    <= period_d;
      pwm_cnt_q   <= pwm_cnt_d;
      pwm_level_q <= pwm_level_d;
      load_q      <= load_d;
      aud_pwm_q   <= aud_pwm_d;
      aud_sd_q    <= aud_sd_d;
      recording_q <= recording_d;
      playing_q   <= playing_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    period_d    = period_q;
    pwm_cnt_d   = pwm_cnt_q;
    pwm_level_d = pwm_level_q;
    mem_we_c    = 1'b0;
    strobe_c    = 1'b0;
    rd_addr_c   = '0;

    unique case (state_q)
      IDLE: begin
        if (start_record) begin
          state_d  = RECORD;
          wr_ptr_d = '0;
          count_d  = '0;
        end else if (start_play && (count_q != '0)) begin
          state_d     = PLAY;
          rd_ptr_d    = '0;
          period_d    = '0;
          pwm_cnt_d   = '0;
          pwm_level_d = '0;
        end
      end

      RECORD: begin
        if (amplitude_valid) begin
          mem_we_c = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          count_d  = count_q + CW'(1);
          if (count_q == CW'(DEPTH - 1)) begin
            state_d = IDLE;
          end
        end
        if (stop) begin
          state_d = IDLE;
        end
      end

      PLAY: begin
        pwm_cnt_d = pwm_cnt_q + DW'(1);
        period_d  = (period_q == PW'(SAMPLE_PERIOD - 1)) ? '0 : period_q + PW'(1);
        if (period_q == '0) begin
          if (rd_ptr_q == count_q) begin
`ifdef PLAYBACK_LOOP_EN
            strobe_c  = 1'b1;
            rd_addr_c = '0;
            rd_ptr_d  = CW'(1);
`else
            state_d   = IDLE;
`endif
          end else begin
            strobe_c  = 1'b1;
            rd_addr_c = rd_ptr_q[AW-1:0];
            rd_ptr_d  = rd_ptr_q + CW'(1);
          end
        end
        // RAM data lands one cycle after the strobe; level follows a cycle later.
        if (load_q) begin
          pwm_level_d = rd_data_q;
        end
        if (stop) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    load_d      = strobe_c;
    recording_d = (state_d == RECORD);
    playing_d   = (state_d == PLAY);
    aud_sd_d    = (state_d == PLAY);
    aud_pwm_d   = (state_d == PLAY) && (pwm_cnt_q < pwm_level_q);
  end

  assign aud_pwm      = aud_pwm_q;
  assign aud_sd       = aud_sd_q;
  assign recording    = recording_q;
  assign playing      = playing_q;
  assign sample_count = count_q;

endmodule
